// File: rtl/pcie_csr_responder.sv
// PCIe feature CSR responder: DFH, scratchpad, status and testpad.
// Optional build macro PCIE_CSR_FLR_CNT_EN adds the FLR counter.
module pcie_csr_responder #(
  parameter int          ADDR_W          = 16,
  parameter logic [63:0] DFH_VALUE       = 64'h3000000010000020,
  parameter int          FLR_HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_req_valid,
  output logic              csr_req_ready,
  input  logic              csr_req_write,
  input  logic [ADDR_W-1:0] csr_req_addr,
  input  logic [63:0]       csr_req_wdata,
  input  logic [7:0]        csr_req_be,
  output logic              csr_rsp_valid,
  input  logic              csr_rsp_ready,
  output logic [63:0]       csr_rsp_data,
  output logic              csr_rsp_error,
  input  logic              flr_req,
  output logic              flr_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR,
    S_HOLD,
    S_ACK
  } flr_state_e;

  localparam logic [ADDR_W-1:0] OFF_DFH = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_SCR = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFF_STS = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] OFF_TPD = ADDR_W'(8'h28);
  localparam logic [15:0] HOLD_LAST = 16'(FLR_HOLD_CYCLES - 1);

  flr_state_e  state_q;
  logic [15:0] hold_cnt_q;
  logic        flr_ack_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_data_q;
  logic        rsp_error_q;
  logic [63:0] scratch_q, scratch_d;
  logic [63:0] testpad_q, testpad_d;
  logic [15:0] flr_cnt;

  logic        wr_acc, rd_acc;
  logic        hit_dfh, hit_scr, hit_sts, hit_tpd;
  logic [63:0] rd_data, status;
  logic        rd_err;

  // Offset bits [2:0] select bytes within a qword and are ignored.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^csr_req_addr[2:0];

  assign csr_req_ready = !rsp_valid_q && (state_q == S_IDLE);
  assign wr_acc = csr_req_valid && csr_req_ready && csr_req_write;
  assign rd_acc = csr_req_valid && csr_req_ready && !csr_req_write;

  assign hit_dfh = csr_req_addr[ADDR_W-1:3] == OFF_DFH[ADDR_W-1:3];
  assign hit_scr = csr_req_addr[ADDR_W-1:3] == OFF_SCR[ADDR_W-1:3];
  assign hit_sts = csr_req_addr[ADDR_W-1:3] == OFF_STS[ADDR_W-1:3];
  assign hit_tpd = csr_req_addr[ADDR_W-1:3] == OFF_TPD[ADDR_W-1:3];

  assign csr_rsp_valid = rsp_valid_q;
  assign csr_rsp_data  = rsp_data_q;
  assign csr_rsp_error = rsp_error_q;
  assign flr_ack       = flr_ack_q;
  assign status        = {48'd0, flr_cnt};

  function automatic logic [63:0] merge_be(
    input logic [63:0] old_v,
    input logic [63:0] new_v,
    input logic [7:0]  be
  );
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Read mux; unmapped offsets flag an error with zero data.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      hit_dfh: rd_data = DFH_VALUE;
      hit_scr: rd_data = scratch_q;
      hit_sts: rd_data = status;
      hit_tpd: rd_data = testpad_q;
      default: rd_err  = 1'b1;
    endcase
  end

  // Next-state for the RW registers; scratchpad is wiped by FLR.
  always_comb begin
    scratch_d = scratch_q;
    testpad_d = testpad_q;
    if (state_q == S_CLEAR) begin
      scratch_d = '0;
    end else if (wr_acc && hit_scr) begin
      scratch_d = merge_be(scratch_q, csr_req_wdata, csr_req_be);
    end
    if (wr_acc && hit_tpd) begin
      testpad_d = merge_be(testpad_q, csr_req_wdata, csr_req_be);
    end
  end

  // RW register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch_q <= '0;
      testpad_q <= '0;
    end else begin
      scratch_q <= scratch_d;
      testpad_q <= testpad_d;
    end
  end

`ifdef PCIE_CSR_FLR_CNT_EN
  logic [15:0] flr_cnt_q;
  assign flr_cnt = flr_cnt_q;

  // Saturating count of completed FLR clear phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flr_cnt_q <= '0;
    end else if (state_q == S_CLEAR && flr_cnt_q != 16'hFFFF) begin
      flr_cnt_q <= flr_cnt_q + 16'd1;
    end
  end
`else
  assign flr_cnt = '0;
`endif

  // Single outstanding read response, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else if (rd_acc) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
      rsp_error_q <= rd_err;
    end else if (rsp_valid_q && csr_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // FLR sequencer: drain, clear, hold, then a one-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      flr_ack_q  <= 1'b0;
    end else begin
      flr_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flr_req) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!rsp_valid_q) state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          hold_cnt_q <= '0;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= S_ACK;
            flr_ack_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_csr_responder.sv
// Self-checking bench for pcie_csr_responder: vector table,
// FLR corner sequences and a randomized run against a register model.
module tb_pcie_csr_responder;

  localparam int          HOLD = 16;
  localparam logic [63:0] DFH  = 64'h3000000010000020;
`ifdef PCIE_CSR_FLR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic        flr_req = 1'b0;
  logic        flr_ack;

  int checks = 0;
  int failures = 0;

  // Reference model state: plain register values and a FLR tally.
  logic [63:0] m_scr = '0;
  logic [63:0] m_tpd = '0;
  int          m_flr = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp;
    bit          err;
  } vec_t;
  vec_t tbl[$];

  pcie_csr_responder #(
    .ADDR_W(16),
    .DFH_VALUE(DFH),
    .FLR_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr_req_valid(req_valid),
    .csr_req_ready(req_ready),
    .csr_req_write(req_write),
    .csr_req_addr(req_addr),
    .csr_req_wdata(req_wdata),
    .csr_req_be(req_be),
    .csr_rsp_valid(rsp_valid),
    .csr_rsp_ready(rsp_ready),
    .csr_rsp_data(rsp_data),
    .csr_rsp_error(rsp_error),
    .flr_req(flr_req),
    .flr_ack(flr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bytes_upd(input logic [63:0] o,
      input logic [63:0] n, input logic [7:0] be);
    logic [63:0] mask;
    for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{be[i]}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [63:0] d,
                             input logic [7:0] be);
    if (a / 8 == 1) m_scr = bytes_upd(m_scr, d, be);
    if (a / 8 == 5) m_tpd = bytes_upd(m_tpd, d, be);
  endtask

  task automatic model_read(input logic [15:0] a, output logic [63:0] d,
                            output bit e);
    e = 1'b0;
    case (a / 8)
      0: d = DFH;
      1: d = m_scr;
      2: d = CNT_EN ? 64'(m_flr) : 64'd0;
      5: d = m_tpd;
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  task automatic model_flr();
    m_scr = '0;
    if (m_flr < 65535) m_flr++;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 60) begin tick(); n++; end
    if (n >= 60) check(name, 0, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d,
                          input logic [7:0] be);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = a; req_wdata = d; req_be = be;
    wait_ready("wr_ready_timeout");
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [63:0] ed,
                         input bit ee, input int stall);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    wait_ready("rd_ready_timeout");
    tick();
    req_valid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_req_ready_low", req_ready, 0);
    check("rd_data", rsp_data, ed);
    check("rd_error", rsp_error, ee);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rd_stall_data", rsp_data, ed);
      check("rd_stall_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_rsp_done", rsp_valid, 0);
    check("rd_ready_back", req_ready, 1);
  endtask

  task automatic do_flr();
    int k = 1;
    flr_req = 1'b1;
    tick();
    flr_req = 1'b0;
    while (!flr_ack && k < 200) begin tick(); k++; end
    check("flr_ack_latency", k, HOLD + 3);
    model_flr();
    tick();
    check("flr_ack_single", flr_ack, 0);
    check("flr_ready_after", req_ready, 1);
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (flr_ack) acks++;
    end
  endtask

  initial begin
    logic [63:0] ed;
    bit          ee;
    int          k;
    int          acks;
    logic [15:0] a;

    tbl.push_back('{0, 16'h0000, 64'h0, 8'h00, DFH, 0});
    tbl.push_back('{1, 16'h0008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0, 0});
    tbl.push_back('{1, 16'h0008, 64'h0, 8'h0F, 64'h0, 0});
    tbl.push_back('{0, 16'h0008, 64'h0, 8'h00, 64'hDEADBEEF_00000000, 0});
    tbl.push_back('{0, 16'h0018, 64'h0, 8'h00, 64'h0, 1});
    tbl.push_back('{1, 16'h0000, '1, 8'hFF, 64'h0, 0});
    tbl.push_back('{0, 16'h0000, 64'h0, 8'h00, DFH, 0});
    tbl.push_back('{0, 16'h0010, 64'h0, 8'h00, 64'h0, 0});
    tbl.push_back('{1, 16'h0028, 64'hAABBCCDD_11223344, 8'hF0, 64'h0, 0});
    tbl.push_back('{0, 16'h002C, 64'h0, 8'h00, 64'hAABBCCDD_00000000, 0});
    tbl.push_back('{1, 16'h0008, '1, 8'h00, 64'h0, 0});
    tbl.push_back('{0, 16'h0008, 64'h0, 8'h00, 64'hDEADBEEF_00000000, 0});
    tbl.push_back('{1, 16'h0010, '1, 8'hFF, 64'h0, 0});
    tbl.push_back('{0, 16'h0013, 64'h0, 8'h00, 64'h0, 0});
    tbl.push_back('{0, 16'h1000, 64'h0, 8'h00, 64'h0, 1});
    tbl.push_back('{1, 16'h0029, 64'h0000_0000_0000_5A00, 8'h02, 64'h0, 0});
    tbl.push_back('{0, 16'h0028, 64'h0, 8'h00, 64'hAABBCCDD_00005A00, 0});

    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_flr_ack", flr_ack, 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      else do_read(tbl[i].addr, tbl[i].exp, tbl[i].err, 0);
    end

    // Basic FLR: scratchpad wiped, testpad kept, counter bumped.
    do_write(16'h0008, 64'h1111, 8'hFF);
    do_write(16'h0028, 64'h2222, 8'hFF);
    do_flr();
    do_read(16'h0008, 64'h0, 0, 0);
    do_read(16'h0028, 64'h2222, 0, 0);
    do_read(16'h0010, CNT_EN ? 64'd1 : 64'd0, 0, 0);

    // FLR raised while a read response is stalled.
    do_write(16'h0008, 64'h5555, 8'hFF);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0008;
    wait_ready("stall_ready_timeout");
    tick();
    req_valid = 1'b0;
    check("stall_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      flr_req = (i == 1);
      check("stall_data", rsp_data, 64'h5555);
      check("stall_req_ready", req_ready, 0);
      tick();
    end
    flr_req = 1'b0;
    check("stall_data_end", rsp_data, 64'h5555);
    rsp_ready = 1'b1;
    check("stall_req_ready_hs", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    k = 1;
    while (!flr_ack && k < 200) begin
      flr_req = (k == 10);
      tick();
      k++;
    end
    flr_req = 1'b0;
    check("stall_flr_latency", k, HOLD + 3);
    model_flr();
    count_acks(40, acks);
    check("stall_extra_ack", acks, 0);
    do_read(16'h0010, CNT_EN ? 64'd2 : 64'd0, 0, 0);
    do_read(16'h0008, 64'h0, 0, 0);

    // Reset while the FLR sequencer sits in HOLD.
    flr_req = 1'b1;
    tick();
    flr_req = 1'b0;
    repeat (8) tick();
    check("hold_ready_low", req_ready, 0);
    rst = 1'b1;
    #1;
    check("rst_hold_ack", flr_ack, 0);
    tick(); tick();
    rst = 1'b0;
    m_scr = '0; m_tpd = '0; m_flr = 0;
    count_acks(40, acks);
    check("rst_hold_no_ack", acks, 0);
    check("rst_hold_ready", req_ready, 1);
    do_read(16'h0028, 64'h0, 0, 0);
    do_read(16'h0010, 64'h0, 0, 0);

    // Randomized traffic against the register model.
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      a = 16'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = 16'($urandom);
      if (k == 0) begin
        do_flr();
      end else if (k < 9) begin
        do_write(a, {$urandom, $urandom}, 8'($urandom));
      end else begin
        model_read(a, ed, ee);
        do_read(a, ed, ee, $urandom_range(0, 3));
      end
    end
    model_read(16'h0010, ed, ee);
    do_read(16'h0010, ed, ee, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcie_csr_responder.md
# pcie_csr_responder

Register-side responder for the PCIe feature's MMIO CSR window; it serves the DFH, scratchpad and testpad accesses that host software and unit benches issue against the PCIe feature offsets. It sits behind the feature-level CSR demux, sees feature-local byte offsets, and returns one read response per read request. It also executes Function Level Reset (FLR) locally, clearing volatile state and acknowledging the reset.

## Interface
Parameters:
- ADDR_W, 16, width of the feature-local byte offset
- DFH_VALUE, 64'h3000000010000020, constant returned at offset 0x00
- FLR_HOLD_CYCLES, 16, cycles spent in HOLD before acknowledging FLR (legal range 1..65535)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- csr_req_valid  in  1  request present
- csr_req_ready  out  1  responder can accept a request
- csr_req_write  in  1  1 = write, 0 = read
- csr_req_addr  in  ADDR_W  feature-local byte offset; bits [2:0] ignored
- csr_req_wdata  in  64  write data
- csr_req_be  in  8  byte enables for writes
- csr_rsp_valid  out  1  read response present
- csr_rsp_ready  in  1  consumer accepts the response
- csr_rsp_data  out  64  read data
- csr_rsp_error  out  1  read targeted an unmapped offset
- flr_req  in  1  single-cycle FLR request pulse
- flr_ack  out  1  single-cycle FLR completion pulse

## Operation
- Register map (64-bit, qword-aligned):
  - 0x00 DFH: RO, reads DFH_VALUE.
  - 0x08 SCRATCHPAD: RW; reset 0; cleared by FLR.
  - 0x10 STATUS: RO; [15:0] saturating FLR count, [63:16] = 0.
  - 0x28 TESTPAD: RW; reset 0; NOT cleared by FLR (sticky until rst).
- Writes: update only enabled bytes; be = 0 is a no-op; writes to RO or unmapped offsets are dropped silently; writes produce no response.
- Reads: exactly one response; unmapped offset returns data 0, error 1; mapped offsets return error 0.
- Only one read outstanding: csr_req_ready = 0 while csr_rsp_valid = 1, or while the FLR FSM is not IDLE.
- Response holds data/error stable while csr_rsp_valid = 1 and csr_rsp_ready = 0.
- FLR FSM:
  - IDLE: on flr_req → DRAIN.
  - DRAIN: wait until no response is pending (immediate if none) → CLEAR.
  - CLEAR: one cycle; SCRATCHPAD := 0; FLR count += 1 (saturates at 16'hFFFF) → HOLD.
  - HOLD: counts FLR_HOLD_CYCLES cycles → ACK.
  - ACK: flr_ack = 1 for one cycle → IDLE.
  - flr_req in any non-IDLE state is ignored.
- flr_req in the same cycle as an accepted request: the request completes normally (write lands, read response generated); FLR enters DRAIN and waits for that response.

## Timing
- Reset values: csr_req_ready 1, csr_rsp_valid 0, csr_rsp_data 0, csr_rsp_error 0, flr_ack 0; FSM IDLE; all registers 0.
- Read accepted (valid & ready) in cycle N → csr_rsp_valid = 1 in cycle N+1 (registered output).
- Write accepted in cycle N → new value visible to a read accepted in cycle N+1.
- csr_req_ready drops in the cycle after a read is accepted and returns in the cycle after the response handshake.
- FLR with no pending response: flr_req in cycle N → DRAIN N+1, CLEAR N+2, HOLD N+3..N+2+FLR_HOLD_CYCLES, flr_ack in cycle N+3+FLR_HOLD_CYCLES, csr_req_ready = 1 in the following cycle.
- rst asserted mid-read or mid-FLR: response is discarded, FSM returns to IDLE, no flr_ack is issued, all registers including TESTPAD return to 0.

## Configuration
- PCIE_CSR_FLR_CNT_EN defined: STATUS[15:0] holds the saturating FLR counter as described.
- Not defined: the counter is not built, STATUS reads all zero, and the FLR sequence is otherwise identical.

## Test plan
- Reset, read 0x00 → rsp data 64'h3000000010000020, error 0, one cycle after acceptance.
- Write 0x08 = 64'hDEADBEEF_CAFEF00D, be 8'hFF, then write 64'h0 with be 8'h0F, read 0x08 → 64'hDEADBEEF_00000000.
- Write 0x08 = 64'h1111, write 0x28 = 64'h2222, pulse flr_req (FLR_HOLD_CYCLES = 16) → flr_ack exactly 19 cycles later; read 0x08 → 0, read 0x28 → 64'h2222, read 0x10 → 1 (0 without PCIE_CSR_FLR_CNT_EN).
- Read 0x18 → data 0, error 1; write 0x00 = all ones, then read 0x00 → still DFH_VALUE.
- Read 0x08 with csr_rsp_ready held low for 5 cycles and flr_req pulsed in the second of those cycles → response data stable, csr_req_ready low throughout, flr_ack 19 cycles after the response handshake; a second flr_req during HOLD → no extra ack, count increments by 1 only.
- Assert rst during HOLD → flr_ack never pulses, csr_req_ready = 1 after reset release, read 0x28 → 0.
